// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: EX-stage widths, EXE_* opcodes/result classes, divider state and CLZ helper
package ex_stage_pkg;
   localparam int N_REG       = 32;
   localparam int N_REG_ADDR  = 5;
   localparam int N_INST_ADDR = 32;
   localparam int N_ALU_OP    = 8;
   localparam int N_ALU_SEL   = 3;
   localparam int N_DIV_CYC   = 32;

   typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_t;

   localparam logic [N_ALU_OP-1:0] EXE_AND_OP   = 8'b00100100;
   localparam logic [N_ALU_OP-1:0] EXE_OR_OP    = 8'b00100101;
   localparam logic [N_ALU_OP-1:0] EXE_XOR_OP   = 8'b00100110;
   localparam logic [N_ALU_OP-1:0] EXE_NOR_OP   = 8'b00100111;
   localparam logic [N_ALU_OP-1:0] EXE_SLL_OP   = 8'b01111100;
   localparam logic [N_ALU_OP-1:0] EXE_SRL_OP   = 8'b00000010;
   localparam logic [N_ALU_OP-1:0] EXE_SRA_OP   = 8'b00000011;
   localparam logic [N_ALU_OP-1:0] EXE_MFHI_OP  = 8'b00010000;
   localparam logic [N_ALU_OP-1:0] EXE_MTHI_OP  = 8'b00010001;
   localparam logic [N_ALU_OP-1:0] EXE_MFLO_OP  = 8'b00010010;
   localparam logic [N_ALU_OP-1:0] EXE_MTLO_OP  = 8'b00010011;
   localparam logic [N_ALU_OP-1:0] EXE_SLT_OP   = 8'b00101010;
   localparam logic [N_ALU_OP-1:0] EXE_SLTU_OP  = 8'b00101011;
   localparam logic [N_ALU_OP-1:0] EXE_ADD_OP   = 8'b00100000;
   localparam logic [N_ALU_OP-1:0] EXE_ADDU_OP  = 8'b00100001;
   localparam logic [N_ALU_OP-1:0] EXE_SUB_OP   = 8'b00100010;
   localparam logic [N_ALU_OP-1:0] EXE_SUBU_OP  = 8'b00100011;
   localparam logic [N_ALU_OP-1:0] EXE_ADDI_OP  = 8'b01010101;
   localparam logic [N_ALU_OP-1:0] EXE_CLZ_OP   = 8'b10110000;
   localparam logic [N_ALU_OP-1:0] EXE_CLO_OP   = 8'b10110001;
   localparam logic [N_ALU_OP-1:0] EXE_MULT_OP  = 8'b00011000;
   localparam logic [N_ALU_OP-1:0] EXE_MULTU_OP = 8'b00011001;
   localparam logic [N_ALU_OP-1:0] EXE_DIV_OP   = 8'b00011010;
   localparam logic [N_ALU_OP-1:0] EXE_DIVU_OP  = 8'b00011011;

   localparam logic [N_ALU_SEL-1:0] EXE_RES_LOGIC       = 3'd1;
   localparam logic [N_ALU_SEL-1:0] EXE_RES_SHIFT       = 3'd2;
   localparam logic [N_ALU_SEL-1:0] EXE_RES_MOVE        = 3'd3;
   localparam logic [N_ALU_SEL-1:0] EXE_RES_ARITHMETIC  = 3'd4;
   localparam logic [N_ALU_SEL-1:0] EXE_RES_JUMP_BRANCH = 3'd6;

   function automatic logic [N_REG-1:0] clz(input logic [N_REG-1:0] x);
      logic [N_REG-1:0] n;
      logic seen;
      n = '0;
      seen = 1'b0;
      for (int i = N_REG - 1; i >= 0; i--) begin
         if (x[i]) seen = 1'b1;
         else if (!seen) n = n + 32'd1;
      end
      return n;
   endfunction
endpackage

// File: rtl/ex_stage_div.sv
// div_unit: radix-2 restoring divider, one quotient bit per cycle; result = {remainder, quotient}
module div_unit
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_en,
   input  logic        hold,
   input  logic        annul,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [63:0] result,
   output logic        ready
);
   div_state_t state;
   logic [31:0] quo, rem, dvs, quo_n, rem_n;
   logic [32:0] trial;
   logic [5:0]  cnt;
   logic        neg_q, neg_r;

   // quo doubles as the shift-in source for the dividend bits
   assign trial = {rem, quo[31]} - {1'b0, dvs};
   assign quo_n = {quo[30:0], ~trial[32]};
   assign rem_n = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
   assign ready = state == DIV_END;

   always_ff @(posedge clk) begin
      if (rst || annul) begin
         state  <= DIV_FREE;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            DIV_FREE: if (start) begin
               if (divisor == '0) state <= DIV_BY_ZERO;
               else begin
                  state <= DIV_ON;
                  quo   <= signed_en && dividend[31] ? -dividend : dividend;
                  dvs   <= signed_en && divisor[31] ? -divisor : divisor;
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= signed_en && (dividend[31] ^ divisor[31]);
                  neg_r <= signed_en && dividend[31];
               end
            end
            DIV_BY_ZERO: begin
               result <= '0;
               state  <= DIV_END;
            end
            DIV_ON: begin
               quo <= quo_n;
               rem <= rem_n;
               cnt <= cnt + 6'd1;
               if (cnt == 6'(N_DIV_CYC - 1)) begin
                  result <= {neg_r ? -rem_n : rem_n, neg_q ? -quo_n : quo_n};
                  state  <= DIV_END;
               end
            end
            DIV_END: if (!hold) state <= DIV_FREE;
            default: state <= DIV_FREE;
         endcase
      end
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage; combinational ALU/HI-LO muxing plus a stalling multi-cycle divider
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_ALU_OP-1:0]    i_alu_op,
   input  logic [N_ALU_SEL-1:0]   i_alu_sel,
   input  logic [N_REG-1:0]       i_reg_0,
   input  logic [N_REG-1:0]       i_reg_1,
   input  logic                   i_reg_wen,
   input  logic [N_REG_ADDR-1:0]  i_reg_waddr,
   input  logic [N_INST_ADDR-1:0] i_link_addr,
   input  logic                   i_delayslot_vld,
   input  logic [N_REG-1:0]       i_hi,
   input  logic [N_REG-1:0]       i_lo,
   input  logic                   i_hold,
   input  logic                   i_annul,
   output logic                   o_reg_wen,
   output logic [N_REG_ADDR-1:0]  o_reg_waddr,
   output logic [N_REG-1:0]       o_reg_wdata,
   output logic                   o_hilo_wen,
   output logic [N_REG-1:0]       o_hi,
   output logic [N_REG-1:0]       o_lo,
   output logic                   o_delayslot_vld,
   output logic                   o_stall_req
);
   logic [31:0] sum, sra_res, logic_res, shift_res, arith_res, move_res, wdata;
   logic [63:0] mul_a, mul_b, product, div_result, hilo;
   logic        is_sub, ovf, is_mult, is_div, div_ready, div_go, hilo_wen;

   assign is_sub = i_alu_op == EXE_SUB_OP || i_alu_op == EXE_SUBU_OP;
   assign sum    = is_sub ? i_reg_0 - i_reg_1 : i_reg_0 + i_reg_1;
   assign ovf    = (i_alu_op == EXE_ADD_OP || i_alu_op == EXE_ADDI_OP) ?
                   i_reg_0[31] == i_reg_1[31] && sum[31] != i_reg_0[31] :
                   i_alu_op == EXE_SUB_OP && i_reg_0[31] != i_reg_1[31] && sum[31] != i_reg_0[31];

   // kept separate so the arithmetic shift is not demoted to unsigned by the mux
   assign sra_res   = $signed(i_reg_1) >>> i_reg_0[4:0];
   assign logic_res = i_alu_op == EXE_AND_OP ? i_reg_0 & i_reg_1 :
                      i_alu_op == EXE_OR_OP  ? i_reg_0 | i_reg_1 :
                      i_alu_op == EXE_XOR_OP ? i_reg_0 ^ i_reg_1 :
                      i_alu_op == EXE_NOR_OP ? ~(i_reg_0 | i_reg_1) : '0;
   assign shift_res = i_alu_op == EXE_SLL_OP ? i_reg_1 << i_reg_0[4:0] :
                      i_alu_op == EXE_SRL_OP ? i_reg_1 >> i_reg_0[4:0] :
                      i_alu_op == EXE_SRA_OP ? sra_res : '0;
   assign arith_res = i_alu_op == EXE_SLT_OP  ? {31'b0, $signed(i_reg_0) < $signed(i_reg_1)} :
                      i_alu_op == EXE_SLTU_OP ? {31'b0, i_reg_0 < i_reg_1} :
                      i_alu_op == EXE_CLZ_OP  ? clz(i_reg_0) :
                      i_alu_op == EXE_CLO_OP  ? clz(~i_reg_0) : sum;
   assign move_res  = i_alu_op == EXE_MFHI_OP ? i_hi : i_alu_op == EXE_MFLO_OP ? i_lo : '0;
   assign wdata     = i_alu_sel == EXE_RES_LOGIC       ? logic_res :
                      i_alu_sel == EXE_RES_SHIFT       ? shift_res :
                      i_alu_sel == EXE_RES_MOVE        ? move_res :
                      i_alu_sel == EXE_RES_ARITHMETIC  ? arith_res :
                      i_alu_sel == EXE_RES_JUMP_BRANCH ? i_link_addr : '0;

   assign is_mult = i_alu_op == EXE_MULT_OP || i_alu_op == EXE_MULTU_OP;
   assign mul_a   = {{32{i_alu_op == EXE_MULT_OP && i_reg_0[31]}}, i_reg_0};
   assign mul_b   = {{32{i_alu_op == EXE_MULT_OP && i_reg_1[31]}}, i_reg_1};
   assign product = mul_a * mul_b;

   assign is_div = i_alu_op == EXE_DIV_OP || i_alu_op == EXE_DIVU_OP;
   assign div_go = is_div && !div_ready && !i_annul;

   div_unit u_div (
      .clk       (i_clk),
      .rst       (i_rst),
      .start     (div_go),
      .signed_en (i_alu_op == EXE_DIV_OP),
      .hold      (i_hold),
      .annul     (i_annul),
      .dividend  (i_reg_0),
      .divisor   (i_reg_1),
      .result    (div_result),
      .ready     (div_ready)
   );

   assign hilo_wen = is_mult || i_alu_op == EXE_MTHI_OP || i_alu_op == EXE_MTLO_OP || (is_div && div_ready);
   assign hilo     = is_mult                  ? product :
                     i_alu_op == EXE_MTHI_OP ? {i_reg_0, i_lo} :
                     i_alu_op == EXE_MTLO_OP ? {i_hi, i_reg_0} :
                     is_div                   ? div_result : '0;

   assign o_reg_wen       = !i_rst && i_reg_wen && !ovf;
   assign o_reg_waddr     = i_rst ? '0 : i_reg_waddr;
   assign o_reg_wdata     = i_rst ? '0 : wdata;
   assign o_hilo_wen      = !i_rst && hilo_wen;
   assign o_hi            = i_rst ? '0 : hilo[63:32];
   assign o_lo            = i_rst ? '0 : hilo[31:0];
   assign o_delayslot_vld = !i_rst && i_delayslot_vld;
   assign o_stall_req     = !i_rst && div_go;
endmodule
